// File: rtl/dm_arbiter.sv
// Two-master arbiter for the shared data-memory port. Each transaction runs IDLE -> ACC -> RESP.
// Define DM_ARB_FIXED_PRIO_EN for fixed priority (master 0 wins ties); round-robin by default.
module dm_arbiter #(
    parameter int AW = 30,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_wr,
    input  logic [2:0]    m0_type,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_ack,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_wr,
    input  logic [2:0]    m1_type,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_ack,
    output logic [DW-1:0] m1_rdata,
    output logic          dm_wr,
    output logic [2:0]    dm_type,
    output logic [AW-1:0] dm_addr,
    output logic [DW-1:0] dm_din,
    input  logic [DW-1:0] dm_dout
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ACC  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]    r_state;
    logic          r_gnt;
    logic [DW-1:0] r_m0_rdata;
    logic [DW-1:0] r_m1_rdata;
    logic          w_any_req;
    logic          w_gnt_new;
    logic          w_grant;

`ifdef DM_ARB_FIXED_PRIO_EN
    always_comb begin
        w_any_req = m0_req | m1_req;
        w_gnt_new = ~m0_req;
    end
`else
    logic r_ptr;

    // On a tie the master selected by r_ptr wins; r_ptr always points away from the last winner.
    always_comb begin
        w_any_req = m0_req | m1_req;
        if (m0_req && m1_req) begin
            w_gnt_new = r_ptr;
        end else begin
            w_gnt_new = ~m0_req;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= 1'b0;
        end else if (w_grant) begin
            r_ptr <= ~w_gnt_new;
        end
    end
`endif

    assign w_grant = (r_state == IDLE) && w_any_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_gnt   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_gnt   <= w_gnt_new;
                        r_state <= ACC;
                    end
                end
                ACC:     r_state <= RESP;
                RESP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Read data is captured on every access, writes included; the master ignores it for writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m0_rdata <= '0;
            r_m1_rdata <= '0;
        end else if (r_state == ACC) begin
            if (r_gnt) begin
                r_m1_rdata <= dm_dout;
            end else begin
                r_m0_rdata <= dm_dout;
            end
        end
    end

    always_comb begin
        dm_type = r_gnt ? m1_type  : m0_type;
        dm_addr = r_gnt ? m1_addr  : m0_addr;
        dm_din  = r_gnt ? m1_wdata : m0_wdata;
        dm_wr   = (r_state == ACC) && (r_gnt ? m1_wr : m0_wr);
        m0_ack  = (r_state == RESP) && !r_gnt;
        m1_ack  = (r_state == RESP) && r_gnt;
    end

    assign m0_rdata = r_m0_rdata;
    assign m1_rdata = r_m1_rdata;

endmodule

// File: tb/tb_dm_arbiter.sv
// Scoreboard bench for dm_arbiter: transaction-level arbitration model plus a small memory.
// Build with DM_ARB_FIXED_PRIO_EN defined to check the fixed-priority variant.
`timescale 1ns/1ps
module tb_dm_arbiter;
    localparam int AW = 30;
    localparam int DW = 32;

    typedef struct packed {
        logic          wr;
        logic [2:0]    typ;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } tx_t;

    typedef struct {
        int            m;
        int            cyc;
        logic [DW-1:0] rdata;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          m0_req = 1'b0, m0_wr = 1'b0;
    logic [2:0]    m0_type = '0;
    logic [AW-1:0] m0_addr = '0;
    logic [DW-1:0] m0_wdata = '0;
    logic          m0_ack;
    logic [DW-1:0] m0_rdata;
    logic          m1_req = 1'b0, m1_wr = 1'b0;
    logic [2:0]    m1_type = '0;
    logic [AW-1:0] m1_addr = '0;
    logic [DW-1:0] m1_wdata = '0;
    logic          m1_ack;
    logic [DW-1:0] m1_rdata;
    logic          dm_wr;
    logic [2:0]    dm_type;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_din;
    logic [DW-1:0] dm_dout;

    dm_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_type(m0_type), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_type(m1_type), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .dm_wr(dm_wr), .dm_type(dm_type), .dm_addr(dm_addr), .dm_din(dm_din),
        .dm_dout(dm_dout)
    );

    always #5 clk = ~clk;

    // Memory access sizes: 0 word, 1 half signed, 2 half unsigned, 3 byte signed, 4 byte unsigned.
    function automatic logic [DW-1:0] ld(input logic [DW-1:0] w, input logic [2:0] t);
        case (t)
            3'd1:    ld = {{16{w[15]}}, w[15:0]};
            3'd2:    ld = {16'h0, w[15:0]};
            3'd3:    ld = {{24{w[7]}}, w[7:0]};
            3'd4:    ld = {24'h0, w[7:0]};
            default: ld = w;
        endcase
    endfunction

    function automatic logic [DW-1:0] st(input logic [DW-1:0] old, input logic [DW-1:0] wd,
                                         input logic [2:0] t);
        case (t)
            3'd1, 3'd2: st = {old[31:16], wd[15:0]};
            3'd3, 3'd4: st = {old[31:8], wd[7:0]};
            default:    st = wd;
        endcase
    endfunction

    logic [DW-1:0] mem [16];
    logic [DW-1:0] init_val [16];
    logic          mem_load = 1'b1;

    assign dm_dout = ld(mem[dm_addr[3:0]], dm_type);

    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 16; i++) mem[i] <= init_val[i];
        end else if (dm_wr) begin
            mem[dm_addr[3:0]] <= st(mem[dm_addr[3:0]], dm_din, dm_type);
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input int act, input int exp);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Stimulus-side state (main process only).
    tx_t           q0[$], q1[$];
    tx_t           cur [2];
    bit            busy [2];
    bit            done [2];
    bit            gap_en = 1'b0;
    bit            manual = 1'b0;
    int            cyc = 0;
    int            next_free = 0;
    int            last_w = 1;
    int            n_wr_model = 0;
    logic [DW-1:0] model_mem [16];

    // Shared between stimulus and monitor.
    exp_t sbq[$];
    int   ack_log[$];

    // Monitor-side state.
    logic [DW-1:0] hold [2];
    logic [DW-1:0] last_rdata [2];
    int            ack_cnt [2];
    int            wr_cnt = 0;
    logic [AW-1:0] last_wr_addr;
    logic [DW-1:0] last_wr_din;

    function automatic logic [DW-1:0] rd(input int m);
        return (m == 1) ? m1_rdata : m0_rdata;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            hold[0] = '0;
            hold[1] = '0;
        end else begin
            if (dm_wr) begin
                wr_cnt++;
                last_wr_addr = dm_addr;
                last_wr_din  = dm_din;
            end
            chk("ack_onehot", 32'(m0_ack & m1_ack), 32'd0);
            while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
                fail_now("missing_ack_cycle", cyc, sbq[0].cyc);
                void'(sbq.pop_front());
            end
            for (int m = 0; m < 2; m++) begin
                if ((m == 0) ? m0_ack : m1_ack) begin
                    ack_log.push_back(m);
                    ack_cnt[m]++;
                    last_rdata[m] = rd(m);
                    if (sbq.size() == 0) begin
                        fail_now("unexpected_ack_master", m, -1);
                    end else begin
                        exp_t e;
                        e = sbq.pop_front();
                        chk("ack_master", 32'(m), 32'(e.m));
                        chk("ack_cycle", 32'(cyc), 32'(e.cyc));
                        chk("rdata", rd(m), e.rdata);
                        chk("rdata_hold_other", rd(1 - m), hold[1 - m]);
                        hold[m] = e.rdata;
                    end
                end
            end
        end
    end

    function automatic int qsz(input int m);
        return (m == 0) ? q0.size() : q1.size();
    endfunction

    function automatic tx_t qpop(input int m);
        if (m == 0) return q0.pop_front();
        return q1.pop_front();
    endfunction

    function automatic tx_t rand_tx();
        tx_t t;
        t.wr    = 1'($urandom_range(0, 1));
        t.typ   = 3'($urandom_range(0, 4));
        t.addr  = AW'($urandom_range(0, 15));
        t.wdata = $urandom;
        return t;
    endfunction

    // One clock: drive masters, then let the reference model decide whether a grant happens now.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (!rst && !manual) begin
            for (int m = 0; m < 2; m++) begin
                if (done[m]) begin
                    busy[m] = 1'b0;
                    done[m] = 1'b0;
                end
                if (!busy[m] && qsz(m) > 0 && (!gap_en || $urandom_range(0, 2) == 0)) begin
                    cur[m]  = qpop(m);
                    busy[m] = 1'b1;
                end
            end
            m0_req = busy[0]; m0_wr = cur[0].wr; m0_type = cur[0].typ;
            m0_addr = cur[0].addr; m0_wdata = cur[0].wdata;
            m1_req = busy[1]; m1_wr = cur[1].wr; m1_type = cur[1].typ;
            m1_addr = cur[1].addr; m1_wdata = cur[1].wdata;
            if (m0_ack) done[0] = 1'b1;
            if (m1_ack) done[1] = 1'b1;
            if (cyc >= next_free && (m0_req || m1_req)) begin
                int   w;
                tx_t  t;
                exp_t e;
`ifdef DM_ARB_FIXED_PRIO_EN
                w = m0_req ? 0 : 1;
`else
                if (m0_req && m1_req) w = 1 - last_w;
                else                  w = m0_req ? 0 : 1;
`endif
                last_w  = w;
                t       = cur[w];
                e.m     = w;
                e.cyc   = cyc + 2;
                e.rdata = ld(model_mem[t.addr[3:0]], t.typ);
                if (t.wr) begin
                    model_mem[t.addr[3:0]] = st(model_mem[t.addr[3:0]], t.wdata, t.typ);
                    n_wr_model++;
                end
                sbq.push_back(e);
                next_free = cyc + 3;
            end
        end
    endtask

    function automatic bit idle();
        return q0.size() == 0 && q1.size() == 0 && !busy[0] && !busy[1] && sbq.size() == 0;
    endfunction

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && !idle(); i++) step();
        if (!idle()) fail_now("wait_idle_timeout", sbq.size(), 0);
    endtask

    initial begin
        int            base;
        int            wr0;
        int            found;
        logic [DW-1:0] old8;
        tx_t           t;

        for (int i = 0; i < 16; i++) begin
            init_val[i]  = $urandom;
            model_mem[i] = init_val[i];
        end
        ack_cnt[0] = 0;
        ack_cnt[1] = 0;
        step();
        step();
        chk("reset_m0_ack", 32'(m0_ack), 32'd0);
        chk("reset_m1_ack", 32'(m1_ack), 32'd0);
        chk("reset_m0_rdata", m0_rdata, 32'd0);
        chk("reset_m1_rdata", m1_rdata, 32'd0);
        chk("reset_dm_wr", 32'(dm_wr), 32'd0);
        mem_load = 1'b0;
        rst = 1'b0;
        next_free = cyc;
        step();
        chk("post_reset_m0_ack", 32'(m0_ack), 32'd0);

        // m0 word write
        wr0 = wr_cnt;
        t.wr = 1'b1; t.typ = 3'd0; t.addr = AW'(4); t.wdata = 32'hDEADBEEF;
        q0.push_back(t);
        wait_idle(50);
        chk("t1_wr_pulses", 32'(wr_cnt - wr0), 32'd1);
        chk("t1_wr_addr", 32'(last_wr_addr), 32'h4);
        chk("t1_wr_din", last_wr_din, 32'hDEADBEEF);
        chk("t1_m1_ack_count", 32'(ack_cnt[1]), 32'd0);
        chk("t1_mem4", mem[4], 32'hDEADBEEF);

        // m1 signed byte read of the same word
        t.wr = 1'b0; t.typ = 3'd3; t.addr = AW'(4); t.wdata = '0;
        q1.push_back(t);
        wait_idle(50);
        chk("t2_m1_rdata", last_rdata[1], 32'hFFFFFFEF);
        chk("t2_no_write", 32'(wr_cnt - wr0), 32'd1);

        // both masters continuously requesting
        base = ack_log.size();
        for (int i = 0; i < 4; i++) begin
            q0.push_back(rand_tx());
            q1.push_back(rand_tx());
        end
        wait_idle(100);
        chk("t3_ack_count", 32'(ack_log.size() - base), 32'd8);
        for (int i = 0; i < 8 && base + i < ack_log.size(); i++) begin
`ifdef DM_ARB_FIXED_PRIO_EN
            chk("t3_order", 32'(ack_log[base + i]), (i < 4) ? 32'd0 : 32'd1);
`else
            chk("t3_order", 32'(ack_log[base + i]), 32'(i % 2));
`endif
        end

        // m0 alone back-to-back, then a tie
        for (int i = 0; i < 3; i++) q0.push_back(rand_tx());
        wait_idle(60);
        base = ack_log.size();
        q1.push_back(rand_tx());
        q0.push_back(rand_tx());
        wait_idle(60);
        chk("t4_tie_count", 32'(ack_log.size() - base), 32'd2);
        if (ack_log.size() > base) begin
`ifdef DM_ARB_FIXED_PRIO_EN
            chk("t4_tie_winner", 32'(ack_log[base]), 32'd0);
`else
            chk("t4_tie_winner", 32'(ack_log[base]), 32'd1);
`endif
        end

        // random traffic with gaps
        gap_en = 1'b1;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 1) == 0) begin
                    if (q0.size() < 4) q0.push_back(rand_tx());
                end else begin
                    if (q1.size() < 4) q1.push_back(rand_tx());
                end
            end
            step();
        end
        wait_idle(3000);

        // reset in the middle of an m0 write's access cycle
        manual = 1'b1;
        old8 = mem[8];
        m0_req = 1'b1; m0_wr = 1'b1; m0_type = 3'd0; m0_addr = AW'(8); m0_wdata = ~old8;
        found = 0;
        for (int i = 0; i < 8 && found == 0; i++) begin
            step();
            if (dm_wr) found = 1;
        end
        chk("rst_acc_reached", 32'(found), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_dm_wr_drop", 32'(dm_wr), 32'd0);
        chk("rst_m0_ack", 32'(m0_ack), 32'd0);
        chk("rst_m0_rdata", m0_rdata, 32'd0);
        chk("rst_m1_rdata", m1_rdata, 32'd0);
        m0_req = 1'b0;
        step();
        chk("rst_hold_m0_ack", 32'(m0_ack), 32'd0);
        step();
        rst = 1'b0;
        busy[0] = 1'b0; busy[1] = 1'b0; done[0] = 1'b0; done[1] = 1'b0;
        last_w = 1;
        next_free = cyc;
        step();
        chk("rst_mem8_unchanged", mem[8], old8);
        chk("rst_no_ack_after", 32'(m0_ack | m1_ack), 32'd0);
        manual = 1'b0;

        // recovery traffic
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                if ($urandom_range(0, 1) == 0) q0.push_back(rand_tx());
                else                           q1.push_back(rand_tx());
            end
            step();
        end
        wait_idle(3000);

        for (int i = 0; i < 16; i++) chk("final_mem", mem[i], model_mem[i]);
        chk("final_write_count", 32'(wr_cnt), 32'(n_wr_model));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Two-requester arbiter sharing the single data-memory port (word-addressed, DMType-encoded access size) between master 0 (CPU load/store unit) and master 1 (debug/DMA loader).
- Sequences each access as a fixed 3-state transaction: arbitrate, memory access, response.
- Registers read data and returns a one-cycle ack to the winning master.

Parameters:
- AW, 30, word-address width, matching the memory's addr[31:2].
- DW, 32, data width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- m0_req  input  1  master 0 request; held high until m0_ack.
- m0_wr  input  1  master 0 write (1) / read (0).
- m0_type  input  3  master 0 access size, DMType encoding.
- m0_addr  input  AW  master 0 word address.
- m0_wdata  input  DW  master 0 write data.
- m0_ack  output  1  master 0 one-cycle completion pulse.
- m0_rdata  output  DW  master 0 read data; valid while m0_ack=1.
- m1_req, m1_wr, m1_type, m1_addr, m1_wdata, m1_ack, m1_rdata: same as the m0_* ports, for master 1.
- dm_wr  output  1  memory write enable (DMWr).
- dm_type  output  3  memory DMType.
- dm_addr  output  AW  memory address.
- dm_din  output  DW  memory write data.
- dm_dout  input  DW  memory combinational read data.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-high.
- Reset values: state=IDLE, gnt=0, ptr=0, m0_ack=0, m1_ack=0, m0_rdata=0, m1_rdata=0.
- States: IDLE, ACC, RESP.
- IDLE:
  - No req: stay in IDLE.
  - Exactly one req: register gnt to that master, go to ACC.
  - Both req: grant the master selected by ptr, go to ACC.
  - On every grant, ptr <= ~gnt_new (the other master gets priority next time).
- ACC (exactly 1 cycle):
  - dm_type, dm_addr, dm_din driven from the granted master's signals.
  - dm_wr = granted master's wr; the write commits at the ACC->RESP edge.
  - At that same edge, dm_dout is captured into the granted master's rdata register. Capture also happens on writes; the master ignores it.
  - Go to RESP.
- RESP (exactly 1 cycle):
  - granted master's ack=1; the other master's ack=0.
  - Requests are not sampled in RESP.
  - Go to IDLE.
- Outside ACC:
  - dm_wr=0, forced combinationally from state.
  - dm_type, dm_addr, dm_din still follow the master selected by gnt.
- Latency: 2 cycles from req sampled in IDLE to ack. Throughput: one transaction per 3 cycles.
- Master obligations:
  - Hold req, wr, type, addr, wdata stable from req assertion through the ack cycle.
  - Drop req, or present the next request, in the cycle after ack.
- rdata: holds its value until that master's next ACC capture.
- Non-granted master: its req is ignored until the arbiter returns to IDLE. No starvation: round-robin ptr guarantees service within 2 transactions.
- Deassertion of req while the master is in ACC or RESP: that transaction completes anyway.
- Reset during ACC:
  - State goes to IDLE immediately, so dm_wr drops before the edge and no write commits.
  - The pending ack is lost.
- Reset during RESP: ack is cleared immediately.
- ptr is unaffected by transactions of a lone requester except as defined above: it always points away from the last winner.

Optional Feature:
- Macro: DM_ARB_FIXED_PRIO_EN.
- Defined: master 0 always wins when both request; ptr is removed (tied to 0). Master 1 can starve under continuous master 0 traffic.
- Undefined: round-robin as specified above.

Test Plan:
- Reset, then m0 write (type word, addr 0x4, wdata 0xDEADBEEF) -> dm_wr=1 for exactly one cycle with dm_addr=0x4 and dm_din=0xDEADBEEF; m0_ack pulses 2 cycles after req is sampled; m1_ack stays 0.
- m1 read (type byte, addr 0x4) after the previous test -> dm_wr=0 throughout; m1_ack pulse with m1_rdata=dm_dout sampled in ACC (0xFFFFFFEF with a sign-extending memory model).
- Both req held continuously from reset -> grants m0, m1, m0, m1; acks alternate every 3 cycles. With DM_ARB_FIXED_PRIO_EN defined: only m0 acks.
- m0 req only, for 3 back-to-back transactions -> ack every 3 cycles; then m1 and m0 raise req simultaneously -> m1 wins (ptr points away from the last winner m0).
- Assert rst mid-ACC of an m0 write to addr 0x8 -> dm_wr falls immediately, memory at 0x8 unchanged, no m0_ack, state IDLE, rdata registers = 0.
